keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_debounce.sv | 47 ++++
 rtl/keypad_scanner.sv | 92 +++++++++
 tb/tb_keypad_scanner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a 16-bit matrix scan once it repeats for DEBOUNCE_SCANS full scans
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] scan,
    input  logic        scan_done,
    output logic [15:0] debounced
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [15:0]   cand_q, cand_d, deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // On each completed scan: extend the run of identical scans or restart it, then accept a long enough run
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (scan_done) begin
            if (scan == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cand_d = scan;
                cnt_d  = CW'(1);
            end
            if (cnt_d >= CNT_MAX) deb_d = cand_d;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign debounced = deb_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with synchronizer, column prescaler, debouncing and single-key encode
module keypad_scanner #(
    parameter int SCAN_DIV       = 10_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] col_select,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int KEYS = 16;
    localparam int PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic [3:0]      sync1_q, sync2_q;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      col_q, col_d;
    logic [KEYS-1:0] scan_q, scan_d, deb, deb_prev_q;
    logic            tick, scan_done, new_single;
    logic [3:0]      idx, key_code_q, key_code_d;
    logic            key_valid_q, key_down_q;

    assign tick       = (pre_q == PRE_MAX);
    assign scan_done  = tick && (col_q == 2'd3);
    assign col_select = 4'b0001 << col_q;

    // Prescaler, column advance and capture of the current column into the scan image
    always_comb begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        col_d  = tick ? col_q + 2'd1 : col_q;
        scan_d = scan_q;
        if (tick) begin
            for (int r = 0; r < 4; r++) scan_d[r*4 + int'(col_q)] = sync2_q[r];
        end
    end

    // Rows are asynchronous: two flops before anything looks at them
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            col_q   <= '0;
            scan_q  <= '0;
        end else begin
            sync1_q <= rows;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            col_q   <= col_d;
            scan_q  <= scan_d;
        end
    end

    // The completed scan includes the last column's sample, so the debouncer sees scan_d, not scan_q
    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .scan      (scan_d),
        .scan_done (scan_done),
        .debounced (deb)
    );

    // Report a key only when the matrix goes from idle straight to exactly one key
    always_comb begin
        idx = '0;
        for (int i = 0; i < KEYS; i++) if (deb[i]) idx = 4'(i);
        new_single = (deb_prev_q == '0) && (deb != '0) && ((deb & (deb - KEYS'(1))) == '0);
        key_code_d = new_single ? idx : key_code_q;
    end

    // Registered key outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev_q  <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            deb_prev_q  <= deb;
            key_code_q  <= key_code_d;
            key_valid_q <= new_single;
            key_down_q  <= (deb != '0);
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for the keypad scanner with a modelled 4x4 key matrix
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows, col_select, key_code;
    logic       key_valid, key_down;

    logic [15:0] press = '0;
    logic        gate  = 1'b1;
    logic [3:0]  exp_q[$];
    int          errors = 0, checks = 0, pulses = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .col_select (col_select),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down)
    );

    // Key matrix: a pressed key shorts its row to the driven column
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (col_select[c] && press[r*4 + c] && gate) rows[r] = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pulse must match the next expected key
    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got key_code %0d expected no pulse", key_code);
            end else begin
                chk("key_code_on_pulse", int'(key_code), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_down(input logic v, input int max, input string name, output int n);
        n = 0;
        while (key_down !== v && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(key_down), int'(v));
    endtask

    initial begin
        int n, p0;
        // Reset and column walk
        repeat (3) @(negedge clk);
        chk("rst_col", int'(col_select), 1);
        chk("rst_code", int'(key_code), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_down", int'(key_down), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("col_hold", int'(col_select), 1);
        @(negedge clk);
        chk("col_adv", int'(col_select), 2);
        repeat (12) @(negedge clk);
        chk("col_wrap", int'(col_select), 1);
        repeat (40) @(negedge clk);
        chk("idle_down", int'(key_down), 0);
        chk("idle_code", int'(key_code), 0);
        chk("idle_pulses", pulses, 0);

        // Clean press of key 9 and release
        exp_q.push_back(4'd9);
        press = 16'h0200;
        wait_down(1'b1, 52, "k9_down", n);
        repeat (4) @(negedge clk);
        chk("k9_pulses", pulses, 1);
        chk("k9_code", int'(key_code), 9);
        press = '0;
        wait_down(1'b0, 52, "k9_release", n);
        repeat (20) @(negedge clk);
        chk("k9_release_pulses", pulses, 1);

        // Bouncing key 9 then stable
        p0 = pulses;
        exp_q.push_back(4'd9);
        press = 16'h0200;
        for (int i = 0; i < 10; i++) begin
            repeat (5) @(negedge clk);
            gate = ~gate;
        end
        gate = 1'b1;
        wait_down(1'b1, 52, "bounce_down", n);
        repeat (40) @(negedge clk);
        chk("bounce_pulses", pulses - p0, 1);
        chk("bounce_code", int'(key_code), 9);
        press = '0;
        wait_down(1'b0, 52, "bounce_release", n);
        repeat (20) @(negedge clk);

        // Two keys together, then drop to one: never a pulse
        p0 = pulses;
        press = 16'h8001;
        wait_down(1'b1, 52, "multi_down", n);
        repeat (4) @(negedge clk);
        chk("multi_code", int'(key_code), 9);
        press = 16'h0001;
        repeat (64) @(negedge clk);
        chk("single_after_multi_down", int'(key_down), 1);
        chk("multi_pulses", pulses - p0, 0);
        chk("multi_code_hold", int'(key_code), 9);
        press = '0;
        wait_down(1'b0, 52, "multi_release", n);
        repeat (20) @(negedge clk);

        // Reset in the middle of debouncing key 5
        p0 = pulses;
        press = 16'h0020;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_col", int'(col_select), 1);
        chk("mid_rst_code", int'(key_code), 0);
        chk("mid_rst_down", int'(key_down), 0);
        chk("mid_rst_valid", int'(key_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(key_valid), 0);
        exp_q.push_back(4'd5);
        wait_down(1'b1, 60, "k5_down", n);
        chk("k5_fresh_scans", int'(n >= 30 && n <= 52), 1);
        repeat (4) @(negedge clk);
        chk("k5_code", int'(key_code), 5);
        chk("k5_pulses", pulses - p0, 1);
        press = '0;
        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
